// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: PC generation, instruction fetch and fetch queue.
// Redirects flush the queue and restart fetch at the resolved target.
module fetch_queue_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            branch,
  input  logic            bne,
  input  logic            zero,
  input  logic            jump,
  input  logic            jr,
  input  logic [XLEN-1:0] br_pc,
  input  logic [XLEN-1:0] offset,
  input  logic [27:0]     jump_target,
  input  logic [XLEN-1:0] jr_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_link
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic [XLEN-1:0] br_pc4;
  logic [XLEN-1:0] target;
  logic            take_beq;
  logic            take_bne;
  logic            redirect;
  logic            push;
  logic            pop;
  logic [CW-1:0]   count;
  logic [CW-1:0]   occ;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [XLEN-1:0] instr_q [DEPTH];
  logic [XLEN-1:0] pc_q    [DEPTH];

  assign take_beq = branch & zero;
  assign take_bne = bne & ~zero;
  assign redirect = take_beq | take_bne | jump | jr;
  assign br_pc4   = br_pc + XLEN'(4);

  // Redirect target, taken branches first, then jump, then jr.
  always_comb begin
    target = jr_target;
    if (take_beq | take_bne) begin
      target = br_pc4 + offset;
    end else if (jump) begin
      target = {br_pc4[XLEN-1:28], jump_target};
    end
  end

  // Count the outstanding request so the queue can never overflow.
  assign occ      = count + {{(CW-1){1'b0}}, inflight};
  assign imem_req = reset & ~redirect & (occ < FULL);
  assign imem_addr = fetch_pc;

  assign out_valid = (count != '0);
  assign push      = inflight & ~redirect;
  assign pop       = out_valid & out_ready & ~redirect;

  assign out_instr = instr_q[rd_ptr];
  assign out_pc    = pc_q[rd_ptr];
  assign out_link  = out_pc + XLEN'(8);

  // Fetch PC: load target on redirect, step by 4 per request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= target;
    end else if (imem_req) begin
      fetch_pc <= fetch_pc + XLEN'(4);
    end
  end

  // Track the request whose data returns next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
    end else begin
      inflight    <= imem_req;
      inflight_pc <= fetch_pc;
    end
  end

  // Queue pointers and count; a redirect empties the queue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage, written with the returning word and its PC.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr] <= imem_rdata;
      pc_q[wr_ptr]    <= inflight_pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: directed vectors, corner sequences and
// randomized traffic against a program-order reference model.
module tb_fetch_queue_unit;

  localparam int XLEN = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        branch, bne, zero, jump, jr;
  logic [31:0] br_pc, offset, jr_target;
  logic [27:0] jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_pc, out_link;
  logic [31:0] key = '0;

  int tests = 0;
  int fails = 0;

  fetch_queue_unit #(
    .XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RPC)
  ) dut (
    .clk(clk), .reset(reset),
    .branch(branch), .bne(bne), .zero(zero),
    .jump(jump), .jr(jr),
    .br_pc(br_pc), .offset(offset),
    .jump_target(jump_target), .jr_target(jr_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .out_link(out_link)
  );

  always #5 clk = ~clk;

  // Instruction memory: one-cycle latency, word = addr ^ key.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= imem_addr ^ key;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic        br, bn, z, j, r;
    logic [31:0] bpc, off;
    logic [27:0] jt;
    logic [31:0] jrt, exp;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    branch = 0; bne = 0; zero = 0; jump = 0; jr = 0;
    br_pc = '0; offset = '0; jump_target = '0;
    jr_target = '0;
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic expect_deliver(input logic [31:0] pc);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (out_valid && out_ready) begin
        chk("deliver_pc", out_pc, pc);
        chk("deliver_instr", out_instr, pc ^ key);
        chk("deliver_link", out_link, pc + 32'd8);
        got = 1'b1;
      end
      tick();
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL deliver_timeout: got none want pc %0h", pc);
    end
  endtask

  function automatic logic [31:0] model_target(
    input logic b, input logic n, input logic z,
    input logic j, input logic [31:0] bpc,
    input logic [31:0] off, input logic [27:0] jt,
    input logic [31:0] jrt);
    logic [31:0] seq;
    seq = bpc + 32'd4;
    if (b && z) return seq + off;
    if (n && !z) return seq + off;
    if (j) return {seq[31:28], jt};
    return jrt;
  endfunction

  logic [31:0] exp_pc, ptgt, tgt, hpc, hinstr, rv;
  bit          pred, phold, redir;
  int          ndel;

  initial begin
    vecs[0] = '{1,0,1,0,0, 32'h40, 32'h20, 28'h0, 32'h0,
                32'h64};
    vecs[1] = '{1,1,0,1,0, 32'h100, 32'h10, 28'h0, 32'h0,
                32'h114};
    vecs[2] = '{0,0,0,1,1, 32'hF000_0000, 32'h0,
                28'h000_0100, 32'h500, 32'hF000_0100};
    vecs[3] = '{0,0,0,0,1, 32'h0, 32'h0, 28'h0, 32'h200,
                32'h200};
    vecs[4] = '{1,0,1,0,0, 32'h80, 32'hFFFF_FFF8, 28'h0,
                32'h0, 32'h7C};
    vecs[5] = '{0,1,0,0,0, 32'hFFFF_FFF8, 32'h10, 28'h0,
                32'h0, 32'hC};
    vecs[6] = '{0,1,1,0,1, 32'h0, 32'h0, 28'h0, 32'h300,
                32'h300};
    vecs[7] = '{1,0,1,1,1, 32'h1000, 32'h100, 28'h40,
                32'h700, 32'h1104};

    // Reset state.
    idle_in();
    out_ready = 1'b1;
    reset = 1'b0;
    #3;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_addr", imem_addr, RPC);

    // Basic streaming.
    key = '0;
    do_reset();
    #1;
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, RPC);
    chk("c0_valid", out_valid, 0);
    tick(); #1;
    chk("c1_valid", out_valid, 0);
    tick(); #1;
    chk("c2_valid", out_valid, 1);
    chk("c2_pc", out_pc, 0);
    chk("c2_instr", out_instr, 0);
    chk("c2_link", out_link, 8);
    for (int k = 1; k <= 3; k++) begin
      tick(); #1;
      chk("stream_valid", out_valid, 1);
      chk("stream_pc", out_pc, 4 * k);
      chk("stream_instr", out_instr, 4 * k);
    end

    // Backpressure fills the queue and holds it.
    key = 32'h5A5A_0000;
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      #1;
      if (i >= 2) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_pc", out_pc, 0);
        chk("hold_instr", out_instr, key);
      end
      tick();
    end
    #1;
    chk("full_req", imem_req, 0);
    chk("full_addr", imem_addr, 16);
    out_ready = 1'b1;
    for (int k = 0; k <= 4; k++) expect_deliver(4 * k);

    // Redirect vectors, each while the queue holds entries.
    foreach (vecs[v]) begin
      out_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 5; i++) tick();
      out_ready = 1'b1;
      branch = vecs[v].br; bne = vecs[v].bn;
      zero = vecs[v].z; jump = vecs[v].j; jr = vecs[v].r;
      br_pc = vecs[v].bpc; offset = vecs[v].off;
      jump_target = vecs[v].jt; jr_target = vecs[v].jrt;
      #1;
      chk("vec_redir_req", imem_req, 0);
      tick();
      idle_in();
      #1;
      chk("vec_valid", out_valid, 0);
      chk("vec_req", imem_req, 1);
      chk("vec_addr", imem_addr, vecs[v].exp);
      expect_deliver(vecs[v].exp);
      expect_deliver(vecs[v].exp + 32'd4);
    end

    // Back-to-back redirects: the later one wins.
    out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    jr = 1'b1; jr_target = 32'h800;
    tick();
    jr_target = 32'h900;
    #1;
    chk("b2b_valid", out_valid, 0);
    chk("b2b_addr1", imem_addr, 32'h800);
    chk("b2b_req1", imem_req, 0);
    tick();
    idle_in();
    #1;
    chk("b2b_addr2", imem_addr, 32'h900);
    chk("b2b_req2", imem_req, 1);
    expect_deliver(32'h900);

    // Reset mid-operation with 3 queued and one inflight.
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    #1;
    chk("mid_pre_valid", out_valid, 1);
    reset = 1'b0;
    #1;
    chk("mid_valid", out_valid, 0);
    chk("mid_req", imem_req, 0);
    chk("mid_addr", imem_addr, RPC);
    tick();
    reset = 1'b1;
    out_ready = 1'b1;
    expect_deliver(RPC);
    expect_deliver(RPC + 32'd4);

    // Randomized traffic against the program-order model.
    key = 32'h0F0F_1234;
    do_reset();
    exp_pc = RPC;
    pred = 0; phold = 0; ndel = 0;
    hpc = '0; hinstr = '0; ptgt = '0;
    for (int c = 0; c < 3000; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      idle_in();
      if ($urandom_range(0, 7) == 0) begin
        branch = 1'($urandom_range(0, 1));
        bne = 1'($urandom_range(0, 1));
        zero = 1'($urandom_range(0, 1));
        jump = 1'($urandom_range(0, 1));
        jr = 1'($urandom_range(0, 1));
        rv = $urandom;
        br_pc = rv & 32'hFFFF_FFFC;
        offset = 32'((int'($urandom_range(0, 64)) - 32) * 4);
        rv = $urandom;
        jump_target = 28'(rv) & 28'hFFF_FFFC;
        rv = $urandom;
        jr_target = rv & 32'hFFFF_FFFC;
      end
      #1;
      redir = (branch && zero) || (bne && !zero) || jump || jr;
      tgt = model_target(branch, bne, zero, jump, br_pc,
                         offset, jump_target, jr_target);
      if (pred) begin
        chk("rnd_post_valid", out_valid, 0);
        chk("rnd_post_addr", imem_addr, ptgt);
        if (!redir) chk("rnd_post_req", imem_req, 1);
      end
      if (phold) begin
        chk("rnd_hold_valid", out_valid, 1);
        chk("rnd_hold_pc", out_pc, hpc);
        chk("rnd_hold_instr", out_instr, hinstr);
      end
      if (redir) begin
        chk("rnd_redir_req", imem_req, 0);
        exp_pc = tgt;
      end else if (out_valid && out_ready) begin
        chk("rnd_pc", out_pc, exp_pc);
        chk("rnd_instr", out_instr, exp_pc ^ key);
        chk("rnd_link", out_link, exp_pc + 32'd8);
        exp_pc = exp_pc + 32'd4;
        ndel++;
      end
      phold = out_valid && !out_ready && !redir;
      hpc = out_pc;
      hinstr = out_instr;
      pred = redir;
      ptgt = tgt;
      tick();
    end
    chk("rnd_progress", ndel > 500, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
